// File: rtl/fpu_align_pkg.sv
// ============================================================================
// Module   : fpu_align_pkg
// Brief    : Shared select encoding and constants for the aligned-fraction
//            select stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fpu_align_pkg;

    typedef enum logic [1:0] {
        FRAC_SEL_PASS = 2'b00,
        FRAC_SEL_ZERO = 2'b01,
        FRAC_SEL_ONE  = 2'b10,
        FRAC_SEL_HOLD = 2'b11
    } frac_sel_t;

    // Upper bound on fraction width that one_constant can represent.
    localparam int MAX_FRAC_WIDTH = 128;

    // 1.0 in [x.xxx...] format: integer bit (MSB of a width-bit field) set.
    function automatic logic [MAX_FRAC_WIDTH-1:0] one_constant(input int width);
        logic [MAX_FRAC_WIDTH-1:0] r_one;
        r_one = {{(MAX_FRAC_WIDTH-1){1'b0}}, 1'b1};
        return r_one << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aligned_fraction_lane_mux.sv
// ============================================================================
// Module   : aligned_fraction_lane_mux
// Brief    : Single-lane combinational source select (pass/zero/one/hold)
//            with zero detect on the resolved value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aligned_fraction_lane_mux
    import fpu_align_pkg::*;
#(
    parameter int FRAC_WIDTH = 24
) (
    input  frac_sel_t              i_select,
    input  logic [FRAC_WIDTH-1:0]  i_fraction,
    input  logic [FRAC_WIDTH-1:0]  i_hold,
    output logic [FRAC_WIDTH-1:0]  o_fraction,
    output logic                   o_is_zero
);

    localparam logic [MAX_FRAC_WIDTH-1:0] c_ONE_FULL = one_constant(FRAC_WIDTH);
    localparam logic [FRAC_WIDTH-1:0]     c_ONE      = c_ONE_FULL[FRAC_WIDTH-1:0];

    always_comb begin
        o_fraction = '0;
        case (i_select)
            FRAC_SEL_PASS: o_fraction = i_fraction;
            FRAC_SEL_ZERO: o_fraction = '0;
            FRAC_SEL_ONE:  o_fraction = c_ONE;
            FRAC_SEL_HOLD: o_fraction = i_hold;
            default:       o_fraction = '0;
        endcase
    end

    assign o_is_zero = ~|o_fraction;

endmodule

`default_nettype wire

// File: rtl/aligned_fraction_select_stage.sv
// ============================================================================
// Module   : aligned_fraction_select_stage
// Brief    : Registered multi-lane aligned-fraction selector with per-lane hold
//            registers and a 2-entry (main + skid) valid/ready buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aligned_fraction_select_stage
    import fpu_align_pkg::*;
#(
    parameter int FRAC_WIDTH = 24,
    parameter int LANES      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*LANES-1:0]           in_select,
    input  logic [FRAC_WIDTH*LANES-1:0]  in_fraction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FRAC_WIDTH*LANES-1:0]  out_fraction,
    output logic [LANES-1:0]             out_is_zero
);

    logic [FRAC_WIDTH*LANES-1:0] w_res_frac;
    logic [LANES-1:0]            w_res_zero;
    logic                        w_accept;
    logic                        w_fire;

    logic                        r_m_valid;
    logic [FRAC_WIDTH*LANES-1:0] r_m_frac;
    logic [LANES-1:0]            r_m_zero;
    logic                        r_s_valid;
    logic [FRAC_WIDTH*LANES-1:0] r_s_frac;
    logic [LANES-1:0]            r_s_zero;
    logic [FRAC_WIDTH*LANES-1:0] r_hold;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        aligned_fraction_lane_mux #(
            .FRAC_WIDTH (FRAC_WIDTH)
        ) u_lane_mux (
            .i_select   (frac_sel_t'(in_select[2*gi +: 2])),
            .i_fraction (in_fraction[FRAC_WIDTH*gi +: FRAC_WIDTH]),
            .i_hold     (r_hold[FRAC_WIDTH*gi +: FRAC_WIDTH]),
            .o_fraction (w_res_frac[FRAC_WIDTH*gi +: FRAC_WIDTH]),
            .o_is_zero  (w_res_zero[gi])
        );
    end

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready = ~r_s_valid;
    assign w_accept = in_valid & in_ready;
    assign w_fire   = r_m_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_frac  <= '0;
            r_m_zero  <= '1;
            r_s_valid <= 1'b0;
            r_s_frac  <= '0;
            r_s_zero  <= '1;
        end else begin
            if (w_fire && r_s_valid) begin
                r_m_frac  <= r_s_frac;
                r_m_zero  <= r_s_zero;
                r_s_valid <= 1'b0;
            end else if (w_accept && (w_fire || !r_m_valid)) begin
                r_m_valid <= 1'b1;
                r_m_frac  <= w_res_frac;
                r_m_zero  <= w_res_zero;
            end else if (w_accept) begin
                r_s_valid <= 1'b1;
                r_s_frac  <= w_res_frac;
                r_s_zero  <= w_res_zero;
            end else if (w_fire) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= w_res_frac;
        end
    end

    assign out_valid    = r_m_valid;
    assign out_fraction = r_m_frac;
    assign out_is_zero  = r_m_zero;

endmodule

`default_nettype wire

// File: tb/tb_aligned_fraction_select_stage.sv
// ============================================================================
// Module   : tb_aligned_fraction_select_stage
// Brief    : Directed self-checking bench for aligned_fraction_select_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aligned_fraction_select_stage;

    localparam int FW = 24;
    localparam int LN = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*LN-1:0]  in_select;
    logic [FW*LN-1:0] in_fraction;
    logic             out_valid;
    logic             out_ready;
    logic [FW*LN-1:0] out_fraction;
    logic [LN-1:0]    out_is_zero;

    int checks;
    int errors;

    aligned_fraction_select_stage #(
        .FRAC_WIDTH (FW),
        .LANES      (LN)
    ) u_dut (
        .clk          (clk),
        .reset        (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_select    (in_select),
        .in_fraction  (in_fraction),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fraction (out_fraction),
        .out_is_zero  (out_is_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [3:0] sel, input logic [47:0] frac);
        @(negedge clk);
        in_valid    = v;
        in_select   = sel;
        in_fraction = frac;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [47:0] frac, input logic [1:0] z);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".frac"},  64'(out_fraction), 64'(frac));
        check({tag, ".zero"},  64'(out_is_zero), 64'(z));
    endtask

    initial begin
        logic [47:0] beat;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_select   = '0;
        in_fraction = '0;
        out_ready   = 1'b1;

        #2;
        check_out("reset", 1'b0, 48'h0, 2'b11);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // HOLD before any write yields zero
        drive(1'b1, 4'b1111, {24'hFFFFFF, 24'hFFFFFF});
        check_out("hold_after_reset", 1'b1, 48'h0, 2'b11);

        drive(1'b1, 4'b0000, {24'h800001, 24'h400000});
        check_out("pass", 1'b1, {24'h800001, 24'h400000}, 2'b00);

        drive(1'b1, 4'b0110, {24'h5A5A5A, 24'h0F0F0F});
        check_out("zero_one", 1'b1, {24'h000000, 24'h800000}, 2'b10);

        drive(1'b1, 4'b0000, {24'h123456, 24'hABCDEF});
        check_out("hold_src", 1'b1, {24'h123456, 24'hABCDEF}, 2'b00);
        drive(1'b1, 4'b1111, {24'hFFFFFF, 24'hFFFFFF});
        check_out("hold", 1'b1, {24'h123456, 24'hABCDEF}, 2'b00);

        drive(1'b1, 4'b1100, {24'hFFFFFF, 24'h000000});
        check_out("hold_pass_zero", 1'b1, {24'h123456, 24'h000000}, 2'b01);

        // Unaccepted inputs must not disturb hold state
        drive(1'b0, 4'b0000, {24'h555555, 24'h555555});
        check("idle.valid", 64'(out_valid), 64'd0);
        drive(1'b1, 4'b1111, {24'hFFFFFF, 24'hFFFFFF});
        check_out("hold_after_idle", 1'b1, {24'h123456, 24'h000000}, 2'b01);
        drive(1'b0, 4'b0000, 48'h0);

        // Backpressure: A to M, B to S, C held upstream
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, {24'hA00001, 24'hA00002});
        check_out("bp_A", 1'b1, {24'hA00001, 24'hA00002}, 2'b00);
        check("bp_A.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 4'b0000, {24'hB00001, 24'hB00002});
        check_out("bp_B_stall", 1'b1, {24'hA00001, 24'hA00002}, 2'b00);
        check("bp_B.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 4'b0000, {24'hC00001, 24'hC00002});
        check_out("bp_C_stall", 1'b1, {24'hA00001, 24'hA00002}, 2'b00);
        check("bp_C.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 4'b0000, {24'hC00001, 24'hC00002});
        check_out("bp_C_stall2", 1'b1, {24'hA00001, 24'hA00002}, 2'b00);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("bp_out_B", 1'b1, {24'hB00001, 24'hB00002}, 2'b00);
        check("bp_out_B.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 4'b0000, {24'hC00001, 24'hC00002});
        check_out("bp_out_C", 1'b1, {24'hC00001, 24'hC00002}, 2'b00);
        drive(1'b0, 4'b0000, 48'h0);
        check("bp_drain.valid", 64'(out_valid), 64'd0);

        // Full throughput: 16 beats on 16 consecutive cycles
        for (int i = 0; i < 16; i++) begin
            beat = {24'(i + 1), 24'((i + 1) << 8)};
            drive(1'b1, 4'b0000, beat);
            check_out($sformatf("tput%0d", i), 1'b1, beat, 2'b00);
            check($sformatf("tput%0d.in_ready", i), 64'(in_ready), 64'd1);
        end
        drive(1'b0, 4'b0000, 48'h0);
        check("tput_drain.valid", 64'(out_valid), 64'd0);

        // Reset asserted between edges with M and S full
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, {24'hD00001, 24'hD00002});
        drive(1'b1, 4'b0000, {24'hE00001, 24'hE00002});
        check("stall_full.in_ready", 64'(in_ready), 64'd0);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 48'h0, 2'b11);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        check("post_reset.in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 4'b0000, 48'h0);
        check("post_reset.valid0", 64'(out_valid), 64'd0);
        drive(1'b0, 4'b0000, 48'h0);
        check("post_reset.valid1", 64'(out_valid), 64'd0);
        drive(1'b1, 4'b1111, {24'hFFFFFF, 24'hFFFFFF});
        check_out("post_reset_hold", 1'b1, 48'h0, 2'b11);
        drive(1'b0, 4'b0000, 48'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aligned_fraction_select_stage.md
Name: aligned_fraction_select_stage

Overview:
- Registered, multi-lane successor of the aligned-fraction zero/pass selector in the FPU alignment path.
- Sits between the exponent-compare/alignment shifter and the adder/multiplier mantissa datapath.
- Per lane, chooses one of four sources: aligned fraction, zero, constant 1.0, or the lane's last issued value (hold).
- Carries a valid/ready handshake with a 2-entry skid buffer so downstream stalls do not combinationally back-propagate.

Parameters:
- FRAC_WIDTH, 24, fraction width in [x.xxx...] format; 1 integer bit, FRAC_WIDTH-1 fractional bits; minimum 2.
- LANES, 2, number of independent operand lanes (a, b, ...); minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_select  input  2*LANES  per-lane select code; lane i at [2i+1:2i]
- in_fraction  input  FRAC_WIDTH*LANES  per-lane aligned fraction; lane i at [FRAC_WIDTH*(i+1)-1:FRAC_WIDTH*i]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_fraction  output  FRAC_WIDTH*LANES  selected fractions, same lane packing
- out_is_zero  output  LANES  lane i output fraction is all zeros

Behaviour:
- Select codes per lane:
  - 00 PASS: in_fraction lane.
  - 01 ZERO: all zeros.
  - 10 ONE: MSB=1, rest 0 (1.0).
  - 11 HOLD: lane value of the most recently accepted beat.
- Hold register, per lane:
  - Updates on every accepted input beat (in_valid && in_ready) with that beat's resolved lane value.
  - HOLD on a lane whose hold register has never been written since reset yields zero (the reset value).
- Resolution is combinational at input acceptance. Resolved value and out_is_zero (computed on the resolved value) are captured together.
- Storage: main output register (M) plus skid register (S), each with a valid bit.
- in_ready = !S.valid. It is registered, so it has no combinational path from out_ready.
- Accept (in_valid && in_ready):
  - If M is empty, or M fires this cycle (out_valid && out_ready), the beat loads M.
  - Otherwise the beat loads S.
- M fires with S valid: S moves to M, S is cleared, and in_ready rises next cycle.
- Simultaneous accept and fire with S empty: new beat loads M, M stays valid. This gives full throughput of 1 beat/cycle.
- Latency: an accepted beat appears on out_* the next cycle when the pipe is empty. Order is strictly FIFO.
- out_valid = M.valid. out_fraction and out_is_zero are stable while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-stall):
  - M.valid=0, S.valid=0, out_fraction=0, out_is_zero=all ones, in_ready=1 (1 once reset deasserts), hold registers=0.
  - Beats in flight are discarded.
- in_select and in_fraction are ignored when in_valid=0. No X propagation is permitted from an unaccepted input into state.

Decomposition:
- Package fpu_align_pkg:
  - typedef enum logic [1:0] frac_sel_t {FRAC_SEL_PASS=2'b00, FRAC_SEL_ZERO=2'b01, FRAC_SEL_ONE=2'b10, FRAC_SEL_HOLD=2'b11}.
  - Function one_constant(width) returning the 1.0 pattern.
- Sub-module aligned_fraction_lane_mux: combinational, one lane. Inputs: select, fraction, hold value. Outputs: resolved fraction, is_zero.
- Top instantiates LANES copies via generate and owns the skid and hold state.

Test Plan:
- Reset, then LANES=2, FRAC_WIDTH=24, out_ready=1:
  - Send sel={00,00}, frac={24'h800001, 24'h400000}.
  - Expect next cycle out_valid=1, out_fraction={24'h800001, 24'h400000}, out_is_zero=2'b00.
- Mode coverage:
  - Send sel={01,10}, any frac. Expect lane1=24'h000000 (is_zero=1) and lane0=24'h800000 (is_zero=0).
- Hold:
  - Send PASS {24'h123456, 24'hABCDEF}, then HOLD {11,11} with frac {24'hFFFFFF, 24'hFFFFFF}.
  - Expect the second output to equal {24'h123456, 24'hABCDEF}.
  - Immediately after reset, HOLD yields 0 with is_zero=1.
- Backpressure:
  - Hold out_ready=0 and stream beats A, B, C with in_valid=1.
  - Expect A in M and B in S, then in_ready=0 with C held upstream and out_fraction stable.
  - Release out_ready. Expect A, B, C in order with no loss or duplication.
- Throughput: out_ready=1 with 16 back-to-back beats. Expect 16 outputs on 16 consecutive cycles, in_ready constantly 1.
- Reset mid-stall:
  - With M and S full, assert reset asynchronously between clock edges.
  - Expect out_valid=0, in_ready=1 after release, and no stale beat emitted.
